// File: rtl/miner_job_scheduler.sv
// miner_job_scheduler: sequences a shared pipelined hashing core.
// Accepts 864-bit jobs ({block[607:0], target[255:0]}), loads the core,
// streams nonces NONCE_START..NONCE_END with a valid/ready handshake, then
// reports the first winning {hash, nonce} or the exhaustion sentinel
// {256'hFF..FF, 32'h0}. A new job preempts the running one.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rx_data, data_ready       incoming job packet and its strobe
//   core_block, core_target   job payload held for the core
//   core_start, core_flush    core load / discard pulses
//   core_nonce(_valid)        nonce stream, accepted when core_ready
//   core_found, core_hash,
//   core_found_nonce          result strobe and payload from the core
//   send_data, tx_data        result strobe and {hash, nonce}
//   busy                      high whenever a job is in progress
module miner_job_scheduler #(
  parameter logic [31:0] NONCE_START = 32'h00000000,
  parameter logic [31:0] NONCE_END   = 32'hFFFFFFFF,
  parameter int unsigned PIPE_DEPTH  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [863:0] rx_data,
  input  logic         data_ready,
  output logic [607:0] core_block,
  output logic [255:0] core_target,
  output logic         core_start,
  output logic         core_flush,
  output logic [31:0]  core_nonce,
  output logic         core_nonce_valid,
  input  logic         core_ready,
  input  logic         core_found,
  input  logic [255:0] core_hash,
  input  logic [31:0]  core_found_nonce,
  output logic         send_data,
  output logic [287:0] tx_data,
  output logic         busy
);

  localparam int unsigned BLOCK_W  = 608;
  localparam int unsigned TARGET_W = 256;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned TX_W     = 288;
  localparam int unsigned DRAIN_W  = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);

  localparam logic [TX_W-1:0] SENTINEL = {{256{1'b1}}, 32'h0};

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, REPORT} state_t;

  state_t               state_q, state_d;
  logic [BLOCK_W-1:0]   block_d;
  logic [TARGET_W-1:0]  target_d;
  logic [NONCE_W-1:0]   nonce_d;
  logic [TX_W-1:0]      tx_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 pending_q, pending_d;
  logic                 start_d, flush_d, valid_d, send_d, busy_d;
  logic                 accept, find;

  // An all-ones hash would be indistinguishable from the sentinel, so it is dropped.
  assign accept = core_nonce_valid && core_ready;
  assign find   = core_found && (core_hash != '1) &&
                  ((state_q == ISSUE) || (state_q == DRAIN));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    block_d   = core_block;
    target_d  = core_target;
    nonce_d   = core_nonce;
    tx_d      = tx_data;
    drain_d   = drain_q;
    pending_d = pending_q;
    flush_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_ready) begin
          block_d  = rx_data[863:256];
          target_d = rx_data[255:0];
          state_d  = LOAD;
        end
      end

      LOAD: begin
        nonce_d = NONCE_START;
        state_d = ISSUE;
        if (data_ready) begin
          block_d  = rx_data[863:256];
          target_d = rx_data[255:0];
          flush_d  = 1'b1;
          state_d  = LOAD;
        end
      end

      ISSUE, DRAIN: begin
        if (find) begin
          // A find beats a simultaneous new job; the new job waits as pending.
          tx_d    = {core_hash, core_found_nonce};
          state_d = REPORT;
          if (data_ready) begin
            block_d   = rx_data[863:256];
            target_d  = rx_data[255:0];
            pending_d = 1'b1;
          end
        end else if (data_ready) begin
          block_d  = rx_data[863:256];
          target_d = rx_data[255:0];
          flush_d  = 1'b1;
          state_d  = LOAD;
        end else if (state_q == ISSUE) begin
          if (accept) begin
            // Compare before incrementing so the counter never wraps.
            if (core_nonce == NONCE_END) begin
              if (PIPE_DEPTH == 0) begin
                tx_d    = SENTINEL;
                state_d = REPORT;
              end else begin
                drain_d = DRAIN_W'(PIPE_DEPTH);
                state_d = DRAIN;
              end
            end else begin
              nonce_d = NONCE_W'(core_nonce + 32'd1);
            end
          end
        end else begin
          // DRAIN lasts PIPE_DEPTH cycles; the count reaches 0 on entry to REPORT.
          drain_d = DRAIN_W'(drain_q - DRAIN_W'(1));
          if (drain_q == DRAIN_W'(1)) begin
            tx_d    = SENTINEL;
            state_d = REPORT;
          end
        end
      end

      REPORT: begin
        state_d = IDLE;
        if (data_ready) begin
          block_d  = rx_data[863:256];
          target_d = rx_data[255:0];
        end
        if (pending_q || data_ready) begin
          pending_d = 1'b0;
          state_d   = LOAD;
        end
      end

      default: state_d = IDLE;
    endcase

    // Strobes and levels are decoded from the next state so they register in step with it.
    start_d = (state_d == LOAD);
    valid_d = (state_d == ISSUE);
    send_d  = (state_d == REPORT);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      core_block       <= '0;
      core_target      <= '0;
      core_nonce       <= NONCE_START;
      core_start       <= 1'b0;
      core_flush       <= 1'b0;
      core_nonce_valid <= 1'b0;
      send_data        <= 1'b0;
      tx_data          <= '0;
      busy             <= 1'b0;
      drain_q          <= '0;
      pending_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      core_block       <= block_d;
      core_target      <= target_d;
      core_nonce       <= nonce_d;
      core_start       <= start_d;
      core_flush       <= flush_d;
      core_nonce_valid <= valid_d;
      send_data        <= send_d;
      tx_data          <= tx_d;
      busy             <= busy_d;
      drain_q          <= drain_d;
      pending_q        <= pending_d;
    end
  end

endmodule

// File: tb/tb_miner_job_scheduler.sv
// Directed testbench for miner_job_scheduler (NONCE 0..7, PIPE_DEPTH 3).
// Inputs change and outputs are sampled on the falling edge.
module tb_miner_job_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [863:0] rx_data;
  logic         data_ready;
  logic [607:0] core_block;
  logic [255:0] core_target;
  logic         core_start;
  logic         core_flush;
  logic [31:0]  core_nonce;
  logic         core_nonce_valid;
  logic         core_ready;
  logic         core_found;
  logic [255:0] core_hash;
  logic [31:0]  core_found_nonce;
  logic         send_data;
  logic [287:0] tx_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [287:0] sentinel;
  logic [607:0] exp_blk;
  logic [255:0] exp_tgt;

  miner_job_scheduler #(
    .NONCE_START(32'h0),
    .NONCE_END  (32'h7),
    .PIPE_DEPTH (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .data_ready      (data_ready),
    .core_block      (core_block),
    .core_target     (core_target),
    .core_start      (core_start),
    .core_flush      (core_flush),
    .core_nonce      (core_nonce),
    .core_nonce_valid(core_nonce_valid),
    .core_ready      (core_ready),
    .core_found      (core_found),
    .core_hash       (core_hash),
    .core_found_nonce(core_found_nonce),
    .send_data       (send_data),
    .tx_data         (tx_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [863:0] mk_pkt(input logic [31:0] b, input logic [31:0] t);
    return {{19{b}}, {8{t}}};
  endfunction

  // Present a job for one cycle; afterwards the DUT is in LOAD.
  task automatic send_job(input logic [31:0] b, input logic [31:0] t);
    rx_data    = mk_pkt(b, t);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    exp_blk    = {19{b}};
    exp_tgt    = {8{t}};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, send_data, core_start, core_flush, core_nonce_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b exp 00000",
               {busy, send_data, core_start, core_flush, core_nonce_valid});
    end
    checks++;
    if ({core_block, core_target, tx_data, core_nonce} !== '0) begin
      errors++;
      $display("FAIL reset_data: got tx=%h nonce=%h exp 0", tx_data, core_nonce);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_exhaustion();
    core_ready = 1'b1;
    send_job(32'hB10C0001, 32'h7A700001);
    checks++;
    if ({core_start, busy, core_nonce_valid} !== 3'b110) begin
      errors++;
      $display("FAIL exh_load: got start/busy/valid=%b exp 110", {core_start, busy, core_nonce_valid});
    end
    checks++;
    if (core_block !== exp_blk || core_target !== exp_tgt) begin
      errors++;
      $display("FAIL exh_latch: got tgt=%h exp %h", core_target, exp_tgt);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({core_nonce_valid, core_start, core_nonce} !== {1'b1, 1'b0, 32'(i)}) begin
        errors++;
        $display("FAIL exh_nonce%0d: got valid=%b start=%b nonce=%0d exp 1 0 %0d",
                 i, core_nonce_valid, core_start, core_nonce, i);
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({core_nonce_valid, send_data, busy} !== 3'b001) begin
        errors++;
        $display("FAIL exh_drain%0d: got valid/send/busy=%b exp 001", d, {core_nonce_valid, send_data, busy});
      end
      tick();
    end
    checks++;
    if (send_data !== 1'b1 || tx_data !== sentinel) begin
      errors++;
      $display("FAIL exh_report: got send=%b tx=%h exp 1 %h", send_data, tx_data, sentinel);
    end
    tick();
    checks++;
    if ({send_data, busy} !== 2'b00 || tx_data !== sentinel) begin
      errors++;
      $display("FAIL exh_idle: got send/busy=%b tx=%h exp 00 held", {send_data, busy}, tx_data);
    end
  endtask

  task automatic test_find();
    core_ready = 1'b1;
    send_job(32'hB10C0002, 32'h7A700002);
    tick();
    repeat (5) tick();
    checks++;
    if ({core_nonce_valid, core_nonce} !== {1'b1, 32'd5}) begin
      errors++;
      $display("FAIL find_pre: got valid=%b nonce=%0d exp 1 5", core_nonce_valid, core_nonce);
    end
    core_found       = 1'b1;
    core_hash        = 256'h1234;
    core_found_nonce = 32'h5;
    tick();
    core_found = 1'b0;
    checks++;
    if ({core_nonce_valid, send_data} !== 2'b01 || tx_data !== {256'h1234, 32'h5}) begin
      errors++;
      $display("FAIL find_report: got valid/send=%b tx=%h exp 01 {1234,5}", {core_nonce_valid, send_data}, tx_data);
    end
    tick();
    checks++;
    if ({send_data, busy} !== 2'b00) begin
      errors++;
      $display("FAIL find_idle: got send/busy=%b exp 00", {send_data, busy});
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]  pat;
    logic [31:0] exp_n;
    pat   = 5'b11001;   // bit 0 first: ready = 1,0,0,1,1
    exp_n = 32'd0;
    core_ready = 1'b1;
    send_job(32'hB10C0003, 32'h7A700003);
    tick();
    for (int k = 0; k < 5; k++) begin
      core_ready = pat[k];
      checks++;
      if ({core_nonce_valid, core_nonce} !== {1'b1, exp_n}) begin
        errors++;
        $display("FAIL bp_step%0d: got valid=%b nonce=%0d exp 1 %0d", k, core_nonce_valid, core_nonce, exp_n);
      end
      tick();
      if (pat[k]) exp_n++;
    end
    core_ready = 1'b1;
    for (int n = 3; n < 8; n++) begin
      checks++;
      if (core_nonce !== 32'(n) || core_nonce_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_nonce%0d: got valid=%b nonce=%0d exp 1 %0d", n, core_nonce_valid, core_nonce, n);
      end
      tick();
    end
    repeat (3) tick();
    checks++;
    if (send_data !== 1'b1 || tx_data !== sentinel) begin
      errors++;
      $display("FAIL bp_report: got send=%b tx=%h exp 1 sentinel", send_data, tx_data);
    end
    tick();
  endtask

  task automatic test_preempt();
    int sends;
    sends = 0;
    core_ready = 1'b1;
    send_job(32'hB10C0004, 32'h7A700004);
    tick();
    repeat (3) tick();
    checks++;
    if (core_nonce !== 32'd3) begin
      errors++;
      $display("FAIL pre_at3: got nonce=%0d exp 3", core_nonce);
    end
    send_job(32'hB10C0005, 32'h7A700005);
    checks++;
    if ({core_flush, core_start, core_nonce_valid, send_data} !== 4'b1100) begin
      errors++;
      $display("FAIL pre_flush: got flush/start/valid/send=%b exp 1100",
               {core_flush, core_start, core_nonce_valid, send_data});
    end
    checks++;
    if (core_block !== exp_blk || core_target !== exp_tgt) begin
      errors++;
      $display("FAIL pre_latch: got tgt=%h exp %h", core_target, exp_tgt);
    end
    tick();
    checks++;
    if ({core_flush, core_start, core_nonce_valid, core_nonce} !== {3'b001, 32'd0}) begin
      errors++;
      $display("FAIL pre_restart: got flush/start/valid=%b nonce=%0d exp 001 0",
               {core_flush, core_start, core_nonce_valid}, core_nonce);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (send_data) sends++;
    end
    checks++;
    if (sends !== 1 || tx_data !== sentinel || busy !== 1'b0) begin
      errors++;
      $display("FAIL pre_reports: got sends=%0d busy=%b exp 1 0", sends, busy);
    end
  endtask

  task automatic test_collision_and_reset();
    core_ready = 1'b1;
    send_job(32'hB10C0006, 32'h7A700006);
    tick();
    repeat (2) tick();
    core_found       = 1'b1;
    core_hash        = 256'hBEEF;
    core_found_nonce = 32'h2;
    send_job(32'hB10C0007, 32'h7A700007);
    core_found = 1'b0;
    checks++;
    if ({send_data, core_flush, core_nonce_valid} !== 3'b100 || tx_data !== {256'hBEEF, 32'h2}) begin
      errors++;
      $display("FAIL col_report: got send/flush/valid=%b tx=%h exp 100 {beef,2}",
               {send_data, core_flush, core_nonce_valid}, tx_data);
    end
    checks++;
    if (core_block !== exp_blk) begin
      errors++;
      $display("FAIL col_latch: got blk=%h exp %h", core_block[31:0], exp_blk[31:0]);
    end
    tick();
    checks++;
    if ({core_start, send_data, core_flush} !== 3'b100) begin
      errors++;
      $display("FAIL col_load: got start/send/flush=%b exp 100", {core_start, send_data, core_flush});
    end
    tick();
    checks++;
    if ({core_nonce_valid, core_nonce} !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL col_issue: got valid=%b nonce=%0d exp 1 0", core_nonce_valid, core_nonce);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, send_data, core_start, core_flush, core_nonce_valid} !== 5'b0 ||
        {core_block, core_target, tx_data, core_nonce} !== '0) begin
      errors++;
      $display("FAIL midreset: got busy=%b valid=%b flush=%b tx=%h exp all 0",
               busy, core_nonce_valid, core_flush, tx_data);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_sentinel_and_pending();
    core_ready = 1'b1;
    core_found       = 1'b1;
    core_hash        = 256'h55;
    core_found_nonce = 32'h9;
    tick();
    core_found = 1'b0;
    checks++;
    if ({send_data, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_find: got send/busy=%b exp 00", {send_data, busy});
    end
    send_job(32'hB10C0008, 32'h7A700008);
    tick();
    tick();
    core_found       = 1'b1;
    core_hash        = '1;
    core_found_nonce = 32'h1;
    tick();
    core_found = 1'b0;
    checks++;
    if ({core_nonce_valid, send_data, core_nonce} !== {2'b10, 32'd2}) begin
      errors++;
      $display("FAIL allones_ignored: got valid=%b send=%b nonce=%0d exp 1 0 2",
               core_nonce_valid, send_data, core_nonce);
    end
    repeat (9) tick();
    checks++;
    if (send_data !== 1'b1 || tx_data !== sentinel) begin
      errors++;
      $display("FAIL allones_report: got send=%b tx=%h exp 1 sentinel", send_data, tx_data);
    end
    send_job(32'hB10C0009, 32'h7A700009);
    checks++;
    if ({core_start, send_data, busy} !== 3'b101 || core_block !== exp_blk) begin
      errors++;
      $display("FAIL report_pending: got start/send/busy=%b exp 101", {core_start, send_data, busy});
    end
  endtask

  initial begin
    sentinel         = {{256{1'b1}}, 32'h0};
    rst              = 1'b1;
    rx_data          = '0;
    data_ready       = 1'b0;
    core_ready       = 1'b0;
    core_found       = 1'b0;
    core_hash        = '0;
    core_found_nonce = '0;
    exp_blk          = '0;
    exp_tgt          = '0;
    test_reset();
    test_exhaustion();
    test_find();
    test_backpressure();
    test_preempt();
    test_collision_and_reset();
    test_sentinel_and_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/miner_job_scheduler.md
Name: miner_job_scheduler

Overview:
Sequences a shared pipelined hashing core for the miner.
- Accepts 864-bit work packets (608-bit block header + 256-bit target).
- Loads the core, streams nonces across a configured range, and reports either the first winning {hash, nonce} or an exhaustion sentinel.
- A new job preempts the running one.
- Sits between the receive interface and the hashing core. It replaces the free-running counter/MCU pair with one handshaked controller.

Parameters:
NONCE_START  32'h00000000  first nonce issued per job
NONCE_END  32'hFFFFFFFF  last nonce issued per job (inclusive); must be >= NONCE_START
PIPE_DEPTH  3  core latency in cycles; drain wait after last nonce issue

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
rx_data  input  864  job packet: [863:256] block, [255:0] target
data_ready  input  1  one-cycle strobe: rx_data valid
core_block  output  608  registered block for core
core_target  output  256  registered target for core
core_start  output  1  one-cycle pulse: core loads block/target
core_flush  output  1  one-cycle pulse: core discards in-flight nonces
core_nonce  output  32  nonce presented to core
core_nonce_valid  output  1  core_nonce valid this cycle
core_ready  input  1  core accepts nonce when valid && ready
core_found  input  1  one-cycle strobe: core_hash <= target
core_hash  input  256  winning hash, valid with core_found
core_found_nonce  input  32  nonce producing core_hash
send_data  output  1  one-cycle result strobe
tx_data  output  288  result {hash[255:0], nonce[31:0]}
busy  output  1  high in any state except IDLE

Behaviour:
Reset:
- All outputs are 0, including core_block, core_target and tx_data.
- FSM is in IDLE; pending flag cleared; nonce counter = NONCE_START.
- rst asserted mid-job aborts without a report. core_flush is not pulsed; rst is shared with the core.

States (IDLE, LOAD, ISSUE, DRAIN, REPORT):
- IDLE: on data_ready, latch rx_data into core_block/core_target -> LOAD.
- LOAD: core_start=1 for exactly one cycle; counter <= NONCE_START -> ISSUE.
- ISSUE:
  - core_nonce_valid=1, core_nonce=counter.
  - On valid&&ready: if counter==NONCE_END -> DRAIN with drain count = PIPE_DEPTH; else counter+1.
  - Counter never wraps; the comparison happens before the increment.
- DRAIN: core_nonce_valid=0; drain count decrements each cycle. At 0 with no find -> REPORT with sentinel {256'hFF..FF, 32'h0}.
- REPORT: send_data=1 for one cycle -> LOAD if pending is set (clear pending), else IDLE.
- Timing: tx_data is registered on entry to REPORT and held until the next REPORT. send_data rises the cycle after the deciding event.

Find handling:
- core_found in ISSUE or DRAIN captures {core_hash, core_found_nonce} -> REPORT. Stop issuing the same cycle.
- core_found with core_hash == all-ones is ignored (sentinel collision); treat as no find.
- core_found in IDLE, LOAD or REPORT is ignored.

Preemption:
- data_ready in LOAD, ISSUE or DRAIN: latch the new job, pulse core_flush one cycle, go to LOAD. No report for the aborted job.
- data_ready in REPORT: the report still fires; latch the new job and set pending.
- data_ready and core_found in the same ISSUE/DRAIN cycle: the find wins and is reported; the new job is latched and pending set; no flush.
- data_ready and last-nonce acceptance in the same cycle: preemption wins.

Throughput: with core_ready held high, one nonce per cycle. Job latency to first nonce is 2 cycles (data_ready -> LOAD -> ISSUE).

Test Plan:
- Exhaustion: NONCE_START=0, NONCE_END=7, PIPE_DEPTH=3, core_ready=1, no find.
  - Required: core_start 1 cycle after data_ready; nonces 0..7 issued on consecutive cycles.
  - Required: send_data pulses 3 cycles after nonce 7 is accepted, then 1 more cycle for REPORT.
  - Required: tx_data={256'hFF..FF,32'h0}; busy returns low.
- Find: core_found with hash=256'h1234, nonce=5 during ISSUE.
  - Required: valid drops the next cycle; send_data one cycle later; tx_data={256'h1234,32'h5}.
- Backpressure: core_ready toggled 1,0,0,1,1.
  - Required: core_nonce holds its value while not ready; no nonce skipped or duplicated; counter advances only on acceptance.
- Preempt: second data_ready at nonce 3.
  - Required: core_flush 1 cycle; new block/target latched; core_start next cycle; counter restarts at 0; no send_data for job 1.
- Collision: core_found with data_ready in the same cycle.
  - Required: job 1 result reported; then LOAD and core_start for job 2 without another data_ready.
- Reset and sentinel: rst mid-ISSUE -> all outputs 0 next cycle, IDLE. core_found with hash all-ones -> ignored, issuing continues.
